// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state codes,
// the largest legal BCD digit and a helper that clamps a raw nibble
// into the legal BCD range.
package bcd_down_timer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Nibbles A..F are not valid BCD, so they are loaded as 9.
   function automatic logic [3:0] sanitiseDigit(input logic [3:0] rawDigit);
      return (rawDigit > BCD_MAX) ? BCD_MAX : rawDigit;
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One stage of the BCD borrow chain. A digit only decrements when every
// digit below it is zero; that condition arrives on borrow_in.
module bcd_digit_dec
   import bcd_down_timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   output logic [3:0] next_digit,
   output logic       borrow_out
);

   // Decrement when borrowed from, wrapping 0 to 9.
   always_comb begin
      next_digit = digit;
      if (borrow_in) begin
         next_digit = (digit == 4'd0) ? BCD_MAX : (digit - 4'd1);
      end
   end

   assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer. Loads a sanitised preset, counts down
// one step per tick while running, and flags terminal count at zero.
// Digit 0 occupies bits [3:0].
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int DIGITS = 2
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   preset_value,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  done,
   output logic                  done_pulse
);

   localparam int W = 4 * DIGITS;

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [W-1:0]  count_q;
   logic [W-1:0]  count_d;
   logic          done_pulse_q;
   logic          done_pulse_d;

   logic [W-1:0]  decValue;
   logic [W-1:0]  presetSan;
   logic [DIGITS:0] borrow;
   logic          countIsZero;
   logic          countIsOne;

   // Digit 0 always takes the decrement; a borrow ripples upward through
   // each digit that currently reads zero.
   assign borrow[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : gDigit
      bcd_digit_dec uDigit (
         .digit      (count_q[4*i +: 4]),
         .borrow_in  (borrow[i]),
         .next_digit (decValue[4*i +: 4]),
         .borrow_out (borrow[i+1])
      );
   end

   // A borrow that survives past the top digit means every digit is zero.
   assign countIsZero = borrow[DIGITS];
   assign countIsOne  = (count_q == W'(1));

   // Clamp each preset nibble into 0..9 so the count never holds an
   // illegal BCD digit.
   always_comb begin
      presetSan = '0;
      for (int i = 0; i < DIGITS; i++) begin
         presetSan[4*i +: 4] = sanitiseDigit(preset_value[4*i +: 4]);
      end
   end

   // Next-state logic: load overrides everything, then pause beats start,
   // and ticks only count while running. The tick that brings the count
   // from one to zero also moves the FSM into DONE on the same edge.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (load) begin
         count_d = presetSan;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !pause) begin
                  state_d = countIsZero ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (tick) begin
                  count_d = decValue;
                  if (countIsOne) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSED: begin
               if (start && !pause) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               count_d = '0;
            end
         endcase
      end
      done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   // State, count and the entry pulse all update on the rising edge;
   // reset is sampled synchronously and wins over every other input.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign count      = count_q;
   assign running    = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer. A 2-digit and a 3-digit
// instance share the same stimulus; a decimal reference model predicts
// each cycle's outputs into a scoreboard queue that is drained after
// every clock edge.
module tb_bcd_down_timer;

   localparam int S_IDLE   = 0;
   localparam int S_RUN    = 1;
   localparam int S_PAUSED = 2;
   localparam int S_DONE   = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        load;
   logic        start;
   logic        pause;
   logic        tick;
   logic [11:0] preset3;

   logic [7:0]  count2;
   logic        running2;
   logic        done2;
   logic        pulse2;
   logic [11:0] count3;
   logic        running3;
   logic        done3;
   logic        pulse3;

   int checks = 0;
   int errors = 0;
   int pulses;
   logic monitorOn = 1'b0;

   typedef struct {
      logic [7:0]  c2;
      logic        r2;
      logic        d2;
      logic        p2;
      logic [11:0] c3;
      logic        r3;
      logic        d3;
      logic        p3;
   } expT;

   expT sb[$];

   int   mState [2];
   int   mCount [2];
   logic mPulse [2];
   int   nDigits [2] = '{2, 3};

   // Free-running 100 MHz-style clock.
   always #5 clock = ~clock;

   bcd_down_timer #(.DIGITS(2)) dut2 (
      .clock        (clock),
      .reset        (reset),
      .load         (load),
      .preset_value (preset3[7:0]),
      .start        (start),
      .pause        (pause),
      .tick         (tick),
      .count        (count2),
      .running      (running2),
      .done         (done2),
      .done_pulse   (pulse2)
   );

   bcd_down_timer #(.DIGITS(3)) dut3 (
      .clock        (clock),
      .reset        (reset),
      .load         (load),
      .preset_value (preset3),
      .start        (start),
      .pause        (pause),
      .tick         (tick),
      .count        (count3),
      .running      (running3),
      .done         (done3),
      .done_pulse   (pulse3)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int bcdToInt(input logic [11:0] v, input int n);
      int r;
      int d;
      r = 0;
      for (int i = n - 1; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [11:0] intToBcd(input int n);
      logic [11:0] r;
      int v;
      r = '0;
      v = n;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic digitsOk(input logic [11:0] v, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic modelStep(input int k, input logic rst, input logic ld,
                            input logic [11:0] p, input logic st,
                            input logic ps, input logic tk);
      int prev;
      prev = mState[k];
      if (rst) begin
         mState[k] = S_IDLE;
         mCount[k] = 0;
         mPulse[k] = 1'b0;
      end else if (ld) begin
         mState[k] = S_IDLE;
         mCount[k] = bcdToInt(p, nDigits[k]);
         mPulse[k] = 1'b0;
      end else begin
         case (prev)
            S_IDLE:   if (st && !ps) mState[k] = (mCount[k] == 0) ? S_DONE : S_RUN;
            S_RUN: begin
               if (ps) begin
                  mState[k] = S_PAUSED;
               end else if (tk) begin
                  mCount[k] = mCount[k] - 1;
                  if (mCount[k] == 0) mState[k] = S_DONE;
               end
            end
            S_PAUSED: if (st && !ps) mState[k] = S_RUN;
            default:  mCount[k] = 0;
         endcase
         mPulse[k] = (mState[k] == S_DONE) && (prev != S_DONE);
      end
   endtask

   task automatic compareOutputs();
      expT e;
      e = sb.pop_front();
      checkOutput("count2",   32'(count2),   32'(e.c2));
      checkOutput("running2", 32'(running2), 32'(e.r2));
      checkOutput("done2",    32'(done2),    32'(e.d2));
      checkOutput("pulse2",   32'(pulse2),   32'(e.p2));
      checkOutput("count3",   32'(count3),   32'(e.c3));
      checkOutput("running3", 32'(running3), 32'(e.r3));
      checkOutput("done3",    32'(done3),    32'(e.d3));
      checkOutput("pulse3",   32'(pulse3),   32'(e.p3));
   endtask

   task automatic applyStimulus(input logic rst, input logic ld,
                                input logic [11:0] p, input logic st,
                                input logic ps, input logic tk);
      expT e;
      logic [11:0] tmp;
      reset   = rst;
      load    = ld;
      preset3 = p;
      start   = st;
      pause   = ps;
      tick    = tk;
      modelStep(0, rst, ld, p & 12'h0FF, st, ps, tk);
      modelStep(1, rst, ld, p, st, ps, tk);
      tmp  = intToBcd(mCount[0]);
      e.c2 = tmp[7:0];
      e.r2 = (mState[0] == S_RUN);
      e.d2 = (mState[0] == S_DONE);
      e.p2 = mPulse[0];
      e.c3 = intToBcd(mCount[1]);
      e.r3 = (mState[1] == S_RUN);
      e.d3 = (mState[1] == S_DONE);
      e.p3 = mPulse[1];
      sb.push_back(e);
      @(posedge clock);
      #1;
      compareOutputs();
   endtask

   // Every digit of both counters must stay a legal BCD value.
   always @(negedge clock) begin
      if (monitorOn) begin
         checkOutput("digitRange2", 32'(digitsOk({4'd0, count2}, 2)), 32'd1);
         checkOutput("digitRange3", 32'(digitsOk(count3, 3)), 32'd1);
      end
   end

   // Directed scenarios followed by a short randomised run.
   initial begin
      reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; preset3 = '0;

      applyStimulus(1, 0, 12'h000, 0, 0, 0);
      applyStimulus(1, 0, 12'h000, 0, 0, 0);
      monitorOn = 1'b1;
      checkOutput("rstCount",   32'(count2),   32'h0);
      checkOutput("rstRunning", 32'(running2), 32'h0);
      checkOutput("rstDone",    32'(done2),    32'h0);

      applyStimulus(0, 1, 12'h025, 0, 0, 0);
      checkOutput("load25", 32'(count2), 32'h25);

      applyStimulus(0, 1, 12'h010, 0, 0, 0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 0, 12'h000, 0, 0, 1);
         pulses += int'(pulse2);
      end
      checkOutput("pulseCount", 32'(pulses), 32'd1);
      checkOutput("doneHeld",   32'(done2),  32'd1);

      applyStimulus(0, 1, 12'h005, 0, 0, 0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      applyStimulus(0, 0, 12'h000, 0, 0, 1);
      applyStimulus(0, 0, 12'h000, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12'h000, 0, 1, 1);
      checkOutput("pausedHold", 32'(count2), 32'h03);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      applyStimulus(0, 0, 12'h000, 0, 0, 1);
      checkOutput("resumed", 32'(count2), 32'h02);
      applyStimulus(0, 0, 12'h000, 1, 1, 0);
      checkOutput("startPauseRun", 32'(running2), 32'h0);

      applyStimulus(0, 1, 12'hFFA, 0, 0, 0);
      checkOutput("sanitise2", 32'(count2), 32'h99);
      checkOutput("sanitise3", 32'(count3), 32'h999);
      applyStimulus(0, 1, 12'h000, 0, 0, 0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      checkOutput("zeroStartDone",  32'(done2),  32'h1);
      checkOutput("zeroStartPulse", 32'(pulse2), 32'h1);
      applyStimulus(0, 0, 12'h000, 0, 0, 0);

      applyStimulus(0, 1, 12'h042, 0, 0, 0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      applyStimulus(0, 1, 12'h030, 0, 0, 1);
      checkOutput("loadOverTick", 32'(count2),   32'h30);
      checkOutput("loadToIdle",   32'(running2), 32'h0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      for (int i = 0; i < 13; i++) applyStimulus(0, 0, 12'h000, 0, 0, 1);
      checkOutput("reach17", 32'(count2), 32'h17);
      applyStimulus(1, 1, 12'h055, 1, 0, 1);
      checkOutput("midReset", 32'(count2), 32'h0);

      applyStimulus(0, 1, 12'h100, 0, 0, 0);
      applyStimulus(0, 0, 12'h000, 1, 0, 0);
      for (int i = 0; i < 100; i++) applyStimulus(0, 0, 12'h000, 0, 0, 1);
      checkOutput("wide000",  32'(count3), 32'h000);
      checkOutput("wideDone", 32'(done3),  32'h1);

      for (int r = 0; r < 4; r++) begin
         applyStimulus(0, 1, 12'($urandom_range(0, 4095)), 0, 0, 0);
         applyStimulus(0, 0, 12'h000, 1, 0, 0);
         for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 12'h000,
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 1)));
         end
      end

      monitorOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
